byte_word_packer: RTL and testbench
===================================

# byte_word_packer

Downstream consumer of the 8-bit `data`/`valid` byte stream carried on the team's stream interface. Packs consecutive valid bytes into wide words and buffers completed words in a small FIFO. Presents them on a valid/ready output towards the next stage. The input has no backpressure, so words that cannot be buffered are dropped and counted.

## Interface
- `BYTES_PER_WORD`, default 4: bytes per output word; legal range 2..8.
- `FIFO_DEPTH`, default 4: output word FIFO entries; power of 2, at least 2.
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_data` input 8: input byte.
- `in_valid` input 1: `in_data` is accepted unconditionally on every cycle `in_valid`=1.
- `in_flush` input 1: emit the partially assembled word.
- `out_data` output 8*`BYTES_PER_WORD`: FIFO head word; lane 0 is in the LSBs.
- `out_keep` output `BYTES_PER_WORD`: valid-lane mask of the head word.
- `out_valid` output 1: FIFO is non-empty.
- `out_ready` input 1: downstream accepts the head word.
- `fifo_level` output clog2(`FIFO_DEPTH`)+1: current FIFO occupancy.
- `drop_cnt` output 16: count of dropped words; saturates at 0xFFFF.
- `seq_err` output 1: sequence-error pulse (see Configuration).

## Operation
- **Assembly register.** Holds `lane_cnt`, range 0..`BYTES_PER_WORD`-1, plus partial data.
- **Byte placement.** An accepted byte is written to lane `lane_cnt`, and `lane_cnt` increments.
- **Full word.** When the byte fills the last lane, a push request is raised with `keep` = all ones, and `lane_cnt` returns to 0.
- **Flush.** `in_flush`=1 with `lane_cnt`>0, or with `in_valid` on the same cycle, pushes the partial word.
  - That cycle's byte is included in the pushed word.
  - `keep` has ones for the filled lanes only; unfilled lanes of `out_data` are zero.
  - `lane_cnt` returns to 0.
  - A flush with nothing assembled is a no-op.
- **FIFO push.** The push succeeds when `fifo_level` < `FIFO_DEPTH`, or when a pop happens in the same cycle.
- **Drop.** Otherwise the word is discarded and `drop_cnt` increments (saturating). Assembly continues unaffected.
- **FIFO pop.** Occurs on `out_valid` && `out_ready`.
- **Output stability.** While `out_valid`=1 and `out_ready`=0, `out_data` and `out_keep` are held stable.
- **`fifo_level` update.** +1 for a push only, −1 for a pop only, unchanged when both occur.
- **Pointers.** Read and write pointers are clog2(`FIFO_DEPTH`) bits wide and wrap naturally.
- **Reset values.** `out_valid`=0, `out_data`=0, `out_keep`=0, `fifo_level`=0, `drop_cnt`=0, `seq_err`=0; `lane_cnt`=0 and the partial word is cleared.
- **Reset mid-word.** Asserting `rst` mid-word discards both the partial word and the FIFO contents.

## Timing
- **Push registration.** A word completed or flushed in cycle N is written into the FIFO at the end of cycle N.
- **Output latency.** If the FIFO was empty, `out_valid`=1 from cycle N+1; latency is one cycle from the last byte.
- **Pop effect.** A pop in cycle M presents the next entry, or deasserts `out_valid`, from cycle M+1.
- **Full FIFO with pop.** With the FIFO full, a push and a pop in the same cycle both succeed, and `fifo_level` stays at `FIFO_DEPTH`.
- **Drop counter update.** `drop_cnt` updates in the cycle after the rejected push.
- **Streaming rate.** Continuous `in_valid` produces one push every `BYTES_PER_WORD` cycles. No idle cycles are needed between words.

## Configuration
- Macro: `BYTE_WORD_PACKER_SEQ_CHECK_EN`.
- **Defined:**
  - The block checks that each accepted byte equals the previous accepted byte +1, modulo 256.
  - The first byte after reset only loads the reference.
  - On a mismatch, `seq_err` pulses high for one cycle, in the cycle after the offending byte.
  - The reference is reloaded with the offending byte.
  - Wrap from 0xFF to 0x00 is legal.
- **Undefined:** `seq_err` is tied to 0, and the checker logic is absent.
- In both cases the packing datapath is identical.

## Test plan
- **Basic packing.** Reset, then bytes 0x00..0x07 on consecutive cycles with `out_ready`=1 → two words:
  - 0x03020100 with `keep`=0xF;
  - then 0x07060504;
  - `out_valid` high one cycle after bytes 0x03 and 0x07.
- **Flush, no gap.** Bytes 0x10, 0x11, then `in_flush` alone → word 0x00001110 with `keep`=0x3.
- **Flush with byte.** `in_flush` together with byte 0x12 after 0x10, 0x11 → 0x00121110 with `keep`=0x7.
- **Overflow and drop.** `out_ready`=0, 24 bytes 0x00..0x17 → `fifo_level`=4, `drop_cnt`=2. Then raise `out_ready` → exactly 4 words drain, the first being 0x03020100.
- **Full FIFO, simultaneous push/pop.** FIFO full, with `out_ready`=1 in the cycle a fifth word completes → no drop, `fifo_level` stays 4, `drop_cnt` unchanged.
- **Sequence check and reset.**
  - With `BYTE_WORD_PACKER_SEQ_CHECK_EN`: bytes 0xFE, 0xFF, 0x00, 0x05, 0x06 → exactly one `seq_err` pulse, one cycle after 0x05.
  - Assert `rst` mid-word → all outputs return to 0, and the next word starts at lane 0.

Source files
------------

// File: rtl/byte_word_packer.sv
// Packs an 8-bit byte stream into BYTES_PER_WORD-wide words and queues them in a small output FIFO.
// Optional byte-sequence checker is enabled by defining BYTE_WORD_PACKER_SEQ_CHECK_EN.
module byte_word_packer #(
  parameter int BYTES_PER_WORD = 4,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  input  logic                          in_flush,
  output logic [8*BYTES_PER_WORD-1:0]   out_data,
  output logic [BYTES_PER_WORD-1:0]     out_keep,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   drop_cnt,
  output logic                          seq_err
);

  localparam int W   = 8 * BYTES_PER_WORD;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LCW = $clog2(BYTES_PER_WORD);
  localparam logic [AW:0]    DEPTH_L   = FIFO_DEPTH[AW:0];
  localparam logic [LCW-1:0] LAST_LANE = LCW'(BYTES_PER_WORD - 1);

  logic [LCW-1:0]            lane_cnt;
  logic [W-1:0]              part_data;
  logic [W-1:0]              word_next;
  logic [BYTES_PER_WORD-1:0] keep_next;
  logic                      push_req;
  logic                      push_ok;
  logic                      pop;

  logic [W-1:0]              mem      [FIFO_DEPTH];
  logic [BYTES_PER_WORD-1:0] keep_mem [FIFO_DEPTH];
  logic [AW-1:0]             wr_ptr;
  logic [AW-1:0]             rd_ptr;

  // The word to push always includes this cycle's byte, so a flush with a byte captures it.
  always_comb begin
    word_next = part_data;
    keep_next = '0;
    if (in_valid) begin
      word_next[{lane_cnt, 3'b000} +: 8] = in_data;
    end
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      keep_next[i] = (LCW'(i) < lane_cnt) || (in_valid && (LCW'(i) == lane_cnt));
    end
  end

  assign push_req = (in_valid && (lane_cnt == LAST_LANE)) ||
                    (in_flush && (in_valid || (lane_cnt != '0)));
  assign pop      = out_valid && out_ready;
  assign push_ok  = push_req && ((fifo_level < DEPTH_L) || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_cnt  <= '0;
      part_data <= '0;
    end else if (push_req) begin
      lane_cnt  <= '0;
      part_data <= '0;
    end else if (in_valid) begin
      lane_cnt  <= lane_cnt + LCW'(1);
      part_data <= word_next;
    end
  end

  // When full, a same-cycle pop frees the head slot, which is also where the write lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i]      <= '0;
        keep_mem[i] <= '0;
      end
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr]      <= word_next;
        keep_mem[wr_ptr] <= keep_next;
        wr_ptr           <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push_ok && !pop) begin
        fifo_level <= fifo_level + (AW+1)'(1);
      end else if (pop && !push_ok) begin
        fifo_level <= fifo_level - (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (push_req && !push_ok && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign out_valid = (fifo_level != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign out_keep  = out_valid ? keep_mem[rd_ptr] : '0;

`ifdef BYTE_WORD_PACKER_SEQ_CHECK_EN
  logic [7:0] seq_ref;
  logic       seq_loaded;

  // The first byte after reset only seeds the reference; a mismatch reseeds it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_ref    <= '0;
      seq_loaded <= 1'b0;
      seq_err    <= 1'b0;
    end else begin
      seq_err <= 1'b0;
      if (in_valid) begin
        seq_err    <= seq_loaded && (in_data != (seq_ref + 8'd1));
        seq_ref    <= in_data;
        seq_loaded <= 1'b1;
      end
    end
  end
`else
  assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_byte_word_packer.sv
// Randomised and directed bench for byte_word_packer against a queue-based reference model.
// Honours BYTE_WORD_PACKER_SEQ_CHECK_EN the same way the design does.
module tb_byte_word_packer;

  localparam int BPW   = 4;
  localparam int DEPTH = 4;
  localparam int W     = 8 * BPW;

  logic                        clk = 1'b0;
  logic                        rst = 1'b1;
  logic [7:0]                  in_data = '0;
  logic                        in_valid = 1'b0;
  logic                        in_flush = 1'b0;
  logic [W-1:0]                out_data;
  logic [BPW-1:0]              out_keep;
  logic                        out_valid;
  logic                        out_ready = 1'b0;
  logic [$clog2(DEPTH):0]      fifo_level;
  logic [15:0]                 drop_cnt;
  logic                        seq_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: bytes gathered so far, queued words, counters.
  logic [7:0]  part_q[$];
  logic [63:0] exp_data_q[$];
  logic [63:0] exp_keep_q[$];
  int          exp_drop = 0;
  bit          ref_loaded = 0;
  logic [7:0]  ref_byte = '0;
  bit          exp_seq_err = 0;
  int          seq_pulses = 0;

  byte_word_packer #(.BYTES_PER_WORD(BPW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_flush(in_flush),
    .out_data(out_data), .out_keep(out_keep), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_level(fifo_level), .drop_cnt(drop_cnt), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    part_q.delete();
    exp_data_q.delete();
    exp_keep_q.delete();
    exp_drop    = 0;
    ref_loaded  = 0;
    ref_byte    = '0;
    exp_seq_err = 0;
  endtask

  task automatic check_output();
    check("out_valid", 64'(out_valid), 64'(exp_data_q.size() > 0));
    check("fifo_level", 64'(fifo_level), 64'(exp_data_q.size()));
    check("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
    check("seq_err", 64'(seq_err), 64'(exp_seq_err));
    if (exp_data_q.size() > 0) begin
      check("out_data", 64'(out_data), exp_data_q[0]);
      check("out_keep", 64'(out_keep), exp_keep_q[0]);
    end
    if (seq_err === 1'b1) seq_pulses++;
  endtask

  // Applies one cycle of inputs from spec-level rules on the byte list and word queue.
  task automatic model_step(input bit v, input logic [7:0] d, input bit f, input bit r);
    int          sz;
    bit          pop;
    bit          push;
    logic [63:0] w;
    logic [63:0] k;
    sz   = exp_data_q.size();
    pop  = (sz > 0) && r;
    push = 0;
    w    = '0;
    k    = '0;
    if (v) part_q.push_back(d);
    if ((part_q.size() == BPW) || (f && part_q.size() > 0)) begin
      push = 1;
      for (int i = 0; i < part_q.size(); i++) w |= 64'(part_q[i]) << (8 * i);
      k = (64'd1 << part_q.size()) - 64'd1;
      part_q.delete();
    end
    if (pop) begin
      void'(exp_data_q.pop_front());
      void'(exp_keep_q.pop_front());
    end
    if (push) begin
      if (sz < DEPTH || pop) begin
        exp_data_q.push_back(w);
        exp_keep_q.push_back(k);
      end else if (exp_drop < 65535) begin
        exp_drop++;
      end
    end
`ifdef BYTE_WORD_PACKER_SEQ_CHECK_EN
    exp_seq_err = v && ref_loaded && (d != 8'(ref_byte + 8'd1));
    if (v) begin
      ref_byte   = d;
      ref_loaded = 1;
    end
`else
    exp_seq_err = 0;
`endif
  endtask

  task automatic apply_stimulus(input bit v, input logic [7:0] d, input bit f, input bit r);
    in_valid  = v;
    in_data   = d;
    in_flush  = f;
    out_ready = r;
    check_output();
    model_step(v, d, f, r);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_flush = 1'b0; in_data = '0; out_ready = 1'b0;
    #2;
    model_clear();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_keep", 64'(out_keep), 64'd0);
    check("rst_fifo_level", 64'(fifo_level), 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    check("rst_seq_err", 64'(seq_err), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset();

    $display("[TB] basic packing");
    for (int i = 0; i < 4; i++) apply_stimulus(1, 8'(i), 0, 1);
    check("basic_w0_valid", 64'(out_valid), 64'd1);
    check("basic_w0_data", 64'(out_data), 64'h03020100);
    check("basic_w0_keep", 64'(out_keep), 64'hF);
    for (int i = 4; i < 8; i++) apply_stimulus(1, 8'(i), 0, 1);
    check("basic_w1_data", 64'(out_data), 64'h07060504);

    $display("[TB] flush without byte");
    apply_stimulus(1, 8'h10, 0, 1);
    apply_stimulus(1, 8'h11, 0, 1);
    apply_stimulus(0, 8'h00, 1, 1);
    check("flush_data", 64'(out_data), 64'h00001110);
    check("flush_keep", 64'(out_keep), 64'h3);

    $display("[TB] flush with byte");
    apply_stimulus(1, 8'h10, 0, 1);
    apply_stimulus(1, 8'h11, 0, 1);
    apply_stimulus(1, 8'h12, 1, 1);
    check("flushb_data", 64'(out_data), 64'h00121110);
    check("flushb_keep", 64'(out_keep), 64'h7);
    apply_stimulus(0, 8'h00, 1, 1);

    $display("[TB] overflow and drop");
    do_reset();
    for (int i = 0; i < 24; i++) apply_stimulus(1, 8'(i), 0, 0);
    check("ovf_level", 64'(fifo_level), 64'd4);
    check("ovf_drop", 64'(drop_cnt), 64'd2);
    check("ovf_head", 64'(out_data), 64'h03020100);
    for (int i = 0; i < 4; i++) apply_stimulus(0, 8'h00, 0, 1);
    check("ovf_drained", 64'(out_valid), 64'd0);

    $display("[TB] full fifo with push and pop");
    do_reset();
    for (int i = 0; i < 19; i++) apply_stimulus(1, 8'(i), 0, 0);
    apply_stimulus(1, 8'd19, 0, 1);
    check("full_level", 64'(fifo_level), 64'd4);
    check("full_drop", 64'(drop_cnt), 64'd0);
    check("full_head", 64'(out_data), 64'h07060504);

    $display("[TB] sequence check");
    do_reset();
    seq_pulses = 0;
    apply_stimulus(1, 8'hFE, 0, 1);
    apply_stimulus(1, 8'hFF, 0, 1);
    apply_stimulus(1, 8'h00, 0, 1);
    apply_stimulus(1, 8'h05, 0, 1);
    apply_stimulus(1, 8'h06, 0, 1);
    apply_stimulus(0, 8'h00, 0, 1);
    apply_stimulus(0, 8'h00, 0, 1);
`ifdef BYTE_WORD_PACKER_SEQ_CHECK_EN
    check("seq_pulse_count", 64'(seq_pulses), 64'd1);
`else
    check("seq_pulse_count", 64'(seq_pulses), 64'd0);
`endif

    $display("[TB] reset mid-word");
    for (int i = 0; i < 6; i++) apply_stimulus(1, 8'(8'h30 + i), 0, 0);
    check("pre_rst_level", 64'(fifo_level), 64'd1);
    do_reset();
    for (int i = 0; i < 4; i++) apply_stimulus(1, 8'(8'hA0 + i), 0, 0);
    check("post_rst_data", 64'(out_data), 64'hA3A2A1A0);
    check("post_rst_keep", 64'(out_keep), 64'hF);

    $display("[TB] random traffic");
    do_reset();
    for (int i = 0; i < 600; i++) begin
      apply_stimulus($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 9) == 0,
                     $urandom_range(0, 2) != 0);
    end
    check_output();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
